byte_word_packer: RTL and testbench
===================================

Name: byte_word_packer

Overview:
- Collects a byte-serial valid/ready stream into BYTES-wide words for the downstream EndianByteSwap stage.
- Bytes are packed little-endian: the first accepted byte lands in bits [7:0].
- A partial word can be closed early with inLast; unused upper bytes are zero-filled.
- The output register is decoupled from the accumulator, so full throughput is sustained when outReady is held high.

Parameters:
- BYTES, default 6, number of bytes per output word (>=2).
- CNT_W, default $clog2(BYTES+1), width of the byte-count field; derived, not overridden.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- inByte  in  8  input byte.
- inValid  in  1  inByte is valid.
- inLast  in  1  this byte closes the current word; qualified by inValid.
- inReady  out  1  packer can accept a byte.
- outWord  out  8*BYTES  packed word; byte k is at [8k+7:8k].
- outCount  out  CNT_W  valid bytes in outWord, 1..BYTES.
- outLast  out  1  word was closed by inLast.
- outValid  out  1  outWord/outCount/outLast are valid.
- outReady  in  1  downstream accepts the word.

Behaviour:
- Handshakes:
  - Byte accept = inValid && inReady.
  - Word accept = outValid && outReady.
- State: accumulator acc[8*BYTES], index idx (0..BYTES-1), pending flag with pendCount/pendLast, and the output register (outWord, outCount, outLast, outValid).
- inReady = !pending. It is purely registered-state driven, with no combinational path from inValid, inLast or outReady.
- Non-completing byte (idx < BYTES-1 and !inLast):
  - acc byte[idx] <= inByte; idx <= idx+1.
- Completing byte (idx == BYTES-1 or inLast):
  - The word is acc with byte[idx] = inByte and bytes above idx forced to 0.
  - count = idx+1; last = inLast.
  - If the output slot is free (!outValid || outReady): load the output register; outValid=1 on the next cycle (latency 1 from the completing byte).
  - Otherwise: store the word in acc, set pending, latch count/last.
  - In both cases idx <= 0.
- Pending drain: while pending and the output slot is free, move acc to the output register and clear pending. inReady returns high the following cycle.
- After a word is moved out, acc is cleared to 0, so no stale bytes leak into later partial words.
- Word accept with no new load: outValid <= 0. outWord holds its last value, and is don't-care while outValid=0.
- Output stability: outWord/outCount/outLast must not change while outValid && !outReady.
- Simultaneous events: word accept and a completing byte in the same cycle load the new word directly, keeping outValid=1 with no bubble.
- inLast with idx==BYTES-1: count=BYTES, outLast=1.
- Reset (synchronous, overrides everything, including mid-word or pending):
  - idx=0, acc=0, pending=0, outValid=0, outWord=0, outCount=0, outLast=0.
  - inReady=1 in the cycle after reset deasserts.
  - Partial bytes are discarded.
- Throughput: one byte per cycle sustained with outReady=1.
- Storage: at most two words (output + pending) held.

Decomposition:
- No shared package is required. CNT_W is computed locally from BYTES.
- No sub-module; single always_ff plus next-state logic, about 150 lines.
- The parent instantiates byte_word_packer -> EndianByteSwap #(.BYTES(BYTES)) on outWord.

Test Plan:
1. BYTES=6, outReady=1; bytes ff,ee,dd,cc,bb,aa on consecutive cycles -> one cycle after aa: outValid=1, outWord=48'haabbccddeeff, outCount=6, outLast=0. Through EndianByteSwap this gives 48'hffeeddccbbaa.
2. Bytes 11,22,33 with inLast on 33 -> outWord=48'h000000332211, outCount=3, outLast=1. A following 6-byte word has no residue from 11/22/33.
3. outReady=0; 12 bytes 01..0c -> outWord=48'h060504030201 held stable; pending set after 0c; inReady=0 next cycle; byte 0d is held off. Raise outReady -> 48'h060504030201 then 48'h0c0b0a090807, then 0d is accepted.
4. outReady=1; 18 back-to-back bytes 00..11 -> three words on cycles 6, 12 and 18 after the first byte; inReady never drops; outValid pulses for exactly 1 cycle each.
5. Reset asserted for 1 cycle after 4 bytes, and separately while pending -> outValid=0, inReady=1. Then bytes a1..a6 -> outWord=48'ha6a5a4a3a2a1, outCount=6.
6. inLast on the 6th byte with outValid && !outReady -> goes pending, outLast=1, outCount=6 once it drains. Single-byte word 7f with inLast -> outWord=48'h00000000007f, outCount=1.

Source files
------------

// File: rtl/byte_word_packer.sv
// byte_word_packer: gathers a byte-serial valid/ready stream into BYTES-wide
// little-endian words. A word can be closed early with inLast, and any unused
// upper bytes are zero. The output register is separate from the accumulator.
// One finished word can wait in the accumulator (pending) while the output
// register is stalled.
module byte_word_packer #(
    parameter int BYTES = 6,
    parameter int CNT_W = $clog2(BYTES + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [7:0]           inByte,
    input  logic                 inValid,
    input  logic                 inLast,
    output logic                 inReady,
    output logic [8*BYTES-1:0]   outWord,
    output logic [CNT_W-1:0]     outCount,
    output logic                 outLast,
    output logic                 outValid,
    input  logic                 outReady
);
    localparam int              IDX_W   = $clog2(BYTES);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(BYTES - 1);

    logic [8*BYTES-1:0] acc_q, acc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               pend_q, pend_d;
    logic [CNT_W-1:0]   pend_cnt_q, pend_cnt_d;
    logic               pend_last_q, pend_last_d;
    logic [8*BYTES-1:0] out_word_q, out_word_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic               out_last_q, out_last_d;
    logic               out_valid_q, out_valid_d;

    logic               byte_acc, slot_free, completing;
    logic [8*BYTES-1:0] word_c;
    logic [CNT_W-1:0]   cnt_c;

    // inReady depends only on registered state, so there is no path from
    // inValid, inLast or outReady.
    assign inReady  = !pend_q;
    assign outWord  = out_word_q;
    assign outCount = out_cnt_q;
    assign outLast  = out_last_q;
    assign outValid = out_valid_q;

    // Build the word the current byte would complete, and decide the handshakes.
    always_comb begin
        byte_acc   = inValid && !pend_q;
        slot_free  = !out_valid_q || outReady;
        completing = byte_acc && ((idx_q == IDX_MAX) || inLast);
        cnt_c      = CNT_W'(idx_q) + CNT_W'(1);
        word_c     = '0;
        for (int k = 0; k < BYTES; k++) begin
            if (IDX_W'(k) < idx_q)
                word_c[8*k +: 8] = acc_q[8*k +: 8];
            else if (IDX_W'(k) == idx_q)
                word_c[8*k +: 8] = inByte;
        end
    end

    // Next state: pending drain, completing byte (direct load or park), plain byte.
    always_comb begin
        acc_d       = acc_q;
        idx_d       = idx_q;
        pend_d      = pend_q;
        pend_cnt_d  = pend_cnt_q;
        pend_last_d = pend_last_q;
        out_word_d  = out_word_q;
        out_cnt_d   = out_cnt_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        if (pend_q) begin
            // No byte is accepted while a word is parked. Drain it when the slot frees.
            if (slot_free) begin
                out_word_d  = acc_q;
                out_cnt_d   = pend_cnt_q;
                out_last_d  = pend_last_q;
                out_valid_d = 1'b1;
                acc_d       = '0;
                pend_d      = 1'b0;
            end
        end else if (completing) begin
            idx_d = '0;
            if (slot_free) begin
                out_word_d  = word_c;
                out_cnt_d   = cnt_c;
                out_last_d  = inLast;
                out_valid_d = 1'b1;
                acc_d       = '0;
            end else begin
                acc_d       = word_c;
                pend_d      = 1'b1;
                pend_cnt_d  = cnt_c;
                pend_last_d = inLast;
            end
        end else begin
            if (byte_acc) begin
                for (int k = 0; k < BYTES; k++)
                    if (IDX_W'(k) == idx_q) acc_d[8*k +: 8] = inByte;
                idx_d = idx_q + IDX_W'(1);
            end
            // The word was taken and nothing new was loaded, so the slot goes empty.
            if (out_valid_q && outReady) out_valid_d = 1'b0;
        end
    end

    // State registers. Reset discards any partial or parked word.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q       <= '0;
            idx_q       <= '0;
            pend_q      <= 1'b0;
            pend_cnt_q  <= '0;
            pend_last_q <= 1'b0;
            out_word_q  <= '0;
            out_cnt_q   <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            pend_q      <= pend_d;
            pend_cnt_q  <= pend_cnt_d;
            pend_last_q <= pend_last_d;
            out_word_q  <= out_word_d;
            out_cnt_q   <= out_cnt_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_byte_word_packer.sv
// Bench for byte_word_packer (BYTES=6). A byte-level model pushes expected
// words into a scoreboard queue as bytes are accepted. Words the DUT hands
// over are collected and compared inside each test task.
module tb_byte_word_packer;
    localparam int BYTES = 6;
    localparam int CNT_W = 3;

    typedef struct packed {
        logic [8*BYTES-1:0] w;
        logic [CNT_W-1:0]   c;
        logic               l;
    } wrd_t;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic [7:0]         inByte = 8'h00;
    logic               inValid = 1'b0;
    logic               inLast = 1'b0;
    logic               inReady;
    logic [8*BYTES-1:0] outWord;
    logic [CNT_W-1:0]   outCount;
    logic               outLast;
    logic               outValid;
    logic               outReady = 1'b0;

    int   checks = 0;
    int   errors = 0;
    int   cyc_n = 0;
    int   rdy_low = 0;
    wrd_t exp_q[$];
    wrd_t got_q[$];
    logic [7:0] mbytes[$];
    int   vld_cyc[$];

    byte_word_packer #(.BYTES(BYTES)) dut (
        .clock(clock), .reset(reset),
        .inByte(inByte), .inValid(inValid), .inLast(inLast), .inReady(inReady),
        .outWord(outWord), .outCount(outCount), .outLast(outLast),
        .outValid(outValid), .outReady(outReady)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference model: collect accepted bytes and emit a word on last or when full.
    function automatic void model_byte(input logic [7:0] b, input logic l);
        wrd_t t;
        mbytes.push_back(b);
        if (l || mbytes.size() == BYTES) begin
            t.w = '0;
            for (int i = 0; i < mbytes.size(); i++) t.w[8*i +: 8] = mbytes[i];
            t.c = CNT_W'(mbytes.size());
            t.l = l;
            exp_q.push_back(t);
            mbytes.delete();
        end
    endfunction

    // One clock: drive inputs, sample the pre-edge handshake state, then advance.
    task automatic cyc(input logic v, input logic [7:0] b, input logic l,
                       input logic r, output logic accepted);
        wrd_t t;
        inValid = v; inByte = b; inLast = l; outReady = r;
        accepted = v && inReady;
        if (outValid) vld_cyc.push_back(cyc_n);
        if (!inReady) rdy_low++;
        if (outValid && r) begin
            t.w = outWord; t.c = outCount; t.l = outLast;
            got_q.push_back(t);
        end
        if (accepted) model_byte(b, l);
        @(posedge clock); #1;
        cyc_n++;
        inValid = 1'b0; inLast = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic l, input logic r);
        logic a;
        int n;
        n = 0;
        a = 1'b0;
        while (!a && n < 64) begin
            cyc(1'b1, b, l, r, a);
            n++;
        end
        if (!a) begin
            checks++; errors++;
            $display("FAIL send_timeout byte=%h not accepted within 64 cycles", b);
        end
    endtask

    task automatic idle(input int n, input logic r);
        logic a;
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, r, a);
    endtask

    task automatic do_reset();
        reset = 1'b1; inValid = 1'b0; inLast = 1'b0;
        @(posedge clock); #1;
        cyc_n++;
        reset = 1'b0;
        exp_q.delete(); got_q.delete(); mbytes.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL rst_outValid got=%b exp=0", outValid); end
        checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL rst_inReady got=%b exp=1", inReady); end
        checks++; if (outWord !== 48'h0) begin errors++; $display("FAIL rst_outWord got=%h exp=0", outWord); end
        checks++; if (outCount !== 3'd0 || outLast !== 1'b0) begin errors++; $display("FAIL rst_cnt_last got=%0d/%b exp=0/0", outCount, outLast); end
    endtask

    task automatic test_full_word();
        logic [7:0] bs[6] = '{8'hff, 8'hee, 8'hdd, 8'hcc, 8'hbb, 8'haa};
        logic [47:0] sw;
        idle(1, 1'b1);
        for (int i = 0; i < 6; i++) send(bs[i], 1'b0, 1'b1);
        checks++; if (outValid !== 1'b1) begin errors++; $display("FAIL full_latency outValid got=%b exp=1", outValid); end
        checks++; if (outWord !== 48'haabbccddeeff || outCount !== 3'd6 || outLast !== 1'b0) begin
            errors++; $display("FAIL full_word got=%h/%0d/%b exp=aabbccddeeff/6/0", outWord, outCount, outLast); end
        for (int k = 0; k < 6; k++) sw[8*k +: 8] = outWord[8*(5-k) +: 8];
        checks++; if (sw !== 48'hffeeddccbbaa) begin errors++; $display("FAIL full_swapped got=%h exp=ffeeddccbbaa", sw); end
        idle(2, 1'b1);
        checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL full_valid_drop got=%b exp=0", outValid); end
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL full_sb_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++;
                $display("FAIL full_sb[%0d] got=%h/%0d/%b exp=%h/%0d/%b", i, got_q[i].w, got_q[i].c, got_q[i].l, exp_q[i].w, exp_q[i].c, exp_q[i].l); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_partial();
        send(8'h11, 1'b0, 1'b1); send(8'h22, 1'b0, 1'b1); send(8'h33, 1'b1, 1'b1);
        checks++; if (outValid !== 1'b1 || outWord !== 48'h000000332211 || outCount !== 3'd3 || outLast !== 1'b1) begin
            errors++; $display("FAIL partial_word got=%b/%h/%0d/%b exp=1/000000332211/3/1", outValid, outWord, outCount, outLast); end
        for (int i = 0; i < 6; i++) send(8'(8'h41 + i), 1'b0, 1'b1);
        checks++; if (outWord !== 48'h464544434241 || outCount !== 3'd6) begin
            errors++; $display("FAIL partial_residue got=%h/%0d exp=464544434241/6", outWord, outCount); end
        idle(2, 1'b1);
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL partial_sb_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++;
                $display("FAIL partial_sb[%0d] got=%h/%0d/%b exp=%h/%0d/%b", i, got_q[i].w, got_q[i].c, got_q[i].l, exp_q[i].w, exp_q[i].c, exp_q[i].l); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_backpressure();
        logic a;
        logic any_acc;
        for (int i = 1; i <= 12; i++) send(8'(i), 1'b0, 1'b0);
        checks++; if (outValid !== 1'b1 || outWord !== 48'h060504030201) begin
            errors++; $display("FAIL bp_held got=%b/%h exp=1/060504030201", outValid, outWord); end
        checks++; if (inReady !== 1'b0) begin errors++; $display("FAIL bp_pending inReady got=%b exp=0", inReady); end
        any_acc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 8'h0d, 1'b1, 1'b0, a);
            any_acc |= a;
            checks++; if (outWord !== 48'h060504030201 || outCount !== 3'd6) begin
                errors++; $display("FAIL bp_stable got=%h/%0d exp=060504030201/6", outWord, outCount); end
        end
        checks++; if (any_acc !== 1'b0) begin errors++; $display("FAIL bp_holdoff accepted=%b exp=0", any_acc); end
        send(8'h0d, 1'b1, 1'b1);
        idle(3, 1'b1);
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL bp_sb_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++;
                $display("FAIL bp_sb[%0d] got=%h/%0d/%b exp=%h/%0d/%b", i, got_q[i].w, got_q[i].c, got_q[i].l, exp_q[i].w, exp_q[i].c, exp_q[i].l); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i <= 4; i++) send(8'(i), 1'b0, 1'b1);
        do_reset();
        checks++; if (outValid !== 1'b0 || inReady !== 1'b1) begin
            errors++; $display("FAIL rmid_state got=%b/%b exp=0/1", outValid, inReady); end
        for (int i = 0; i < 6; i++) send(8'(8'hb1 + i), 1'b0, 1'b1);
        idle(2, 1'b1);
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rmid_sb_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++;
                $display("FAIL rmid_sb[%0d] got=%h/%0d/%b exp=%h/%0d/%b", i, got_q[i].w, got_q[i].c, got_q[i].l, exp_q[i].w, exp_q[i].c, exp_q[i].l); end
        end
        exp_q.delete(); got_q.delete();
        for (int i = 1; i <= 12; i++) send(8'(i), 1'b0, 1'b0);
        idle(1, 1'b0);
        checks++; if (inReady !== 1'b0) begin errors++; $display("FAIL rpend_setup inReady got=%b exp=0", inReady); end
        do_reset();
        checks++; if (outValid !== 1'b0 || inReady !== 1'b1 || outWord !== 48'h0) begin
            errors++; $display("FAIL rpend_state got=%b/%b/%h exp=0/1/0", outValid, inReady, outWord); end
        for (int i = 0; i < 6; i++) send(8'(8'ha1 + i), 1'b0, 1'b1);
        checks++; if (outWord !== 48'ha6a5a4a3a2a1 || outCount !== 3'd6) begin
            errors++; $display("FAIL rpend_word got=%h/%0d exp=a6a5a4a3a2a1/6", outWord, outCount); end
        idle(2, 1'b1);
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rpend_sb_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++;
                $display("FAIL rpend_sb[%0d] got=%h/%0d/%b exp=%h/%0d/%b", i, got_q[i].w, got_q[i].c, got_q[i].l, exp_q[i].w, exp_q[i].c, exp_q[i].l); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_back_to_back();
        int c0;
        idle(1, 1'b1);
        exp_q.delete(); got_q.delete();
        vld_cyc.delete();
        rdy_low = 0;
        c0 = cyc_n;
        for (int i = 0; i < 18; i++) send(8'(i), 1'b0, 1'b1);
        idle(2, 1'b1);
        checks++; if (vld_cyc.size() !== 3) begin errors++; $display("FAIL b2b_pulses got=%0d exp=3", vld_cyc.size()); end
        for (int i = 0; i < 3; i++) if (i < vld_cyc.size()) begin
            checks++; if (vld_cyc[i] !== c0 + 6*(i+1)) begin errors++;
                $display("FAIL b2b_cycle[%0d] got=%0d exp=%0d", i, vld_cyc[i] - c0, 6*(i+1)); end
        end
        checks++; if (rdy_low !== 0) begin errors++; $display("FAIL b2b_inReady_drops got=%0d exp=0", rdy_low); end
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL b2b_sb_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++;
                $display("FAIL b2b_sb[%0d] got=%h/%0d/%b exp=%h/%0d/%b", i, got_q[i].w, got_q[i].c, got_q[i].l, exp_q[i].w, exp_q[i].c, exp_q[i].l); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_last_full_pending();
        for (int i = 0; i < 6; i++) send(8'(8'h21 + i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) send(8'(8'h31 + i), 1'b0, 1'b0);
        send(8'h36, 1'b1, 1'b0);
        checks++; if (inReady !== 1'b0 || outWord !== 48'h262524232221) begin
            errors++; $display("FAIL lastfull_pending got=%b/%h exp=0/262524232221", inReady, outWord); end
        idle(4, 1'b1);
        send(8'h7f, 1'b1, 1'b1);
        checks++; if (outValid !== 1'b1 || outWord !== 48'h00000000007f || outCount !== 3'd1 || outLast !== 1'b1) begin
            errors++; $display("FAIL single_byte got=%b/%h/%0d/%b exp=1/00000000007f/1/1", outValid, outWord, outCount, outLast); end
        idle(2, 1'b1);
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL lastfull_sb_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++;
                $display("FAIL lastfull_sb[%0d] got=%h/%0d/%b exp=%h/%0d/%b", i, got_q[i].w, got_q[i].c, got_q[i].l, exp_q[i].w, exp_q[i].c, exp_q[i].l); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_partial();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_last_full_pending();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
